// File: rtl/vertex_plot_if.sv
// vertex_plot_if: point handshake, clear request and z/frame buffer bus.
// slave = plotting block side, master = rasterizer/memory side.
interface vertex_plot_if #(
  parameter int ADDR_W  = 18,
  parameter int COLOR_W = 12
);
  logic                rast_pt_valid;
  logic [2:0][12:0]    rast_pt;
  logic [COLOR_W-1:0]  color;
  logic                rast_pt_ready;
  logic                clear_start;
  logic [ADDR_W-1:0]   zbuf_addr;
  logic [12:0]         zbuf_rd_data;
  logic                zbuf_we;
  logic [12:0]         zbuf_wr_data;
  logic [ADDR_W-1:0]   fb_addr;
  logic                fb_we;
  logic [COLOR_W-1:0]  fb_data;
  logic                busy;
  logic [15:0]         plotted_count;
  logic [15:0]         rejected_count;

  modport slave (
    input  rast_pt_valid, rast_pt, color, clear_start, zbuf_rd_data,
    output rast_pt_ready, zbuf_addr, zbuf_we, zbuf_wr_data,
    output fb_addr, fb_we, fb_data, busy,
    output plotted_count, rejected_count
  );

  modport master (
    output rast_pt_valid, rast_pt, color, clear_start, zbuf_rd_data,
    input  rast_pt_ready, zbuf_addr, zbuf_we, zbuf_wr_data,
    input  fb_addr, fb_we, fb_data, busy,
    input  plotted_count, rejected_count
  );
endinterface

// File: rtl/vertex_plot.sv
// vertex_plot: depth-tested plot sink with buffer clear and counters.
// Ports: clk, rst (async, active-high), bus (vertex_plot_if.slave).
module vertex_plot #(
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int ADDR_W  = 18,
  parameter int COLOR_W = 12,
  parameter int RD_LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  vertex_plot_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_DECIDE,
    S_WRITE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic signed [12:0]  r_z;
  logic [COLOR_W-1:0]  r_col;
  logic [1:0]          r_wait;
  logic                r_we;
  logic [12:0]         r_zwr;
  logic [COLOR_W-1:0]  r_fbd;
  logic [15:0]         r_plot;
  logic [15:0]         r_rej;

  logic [12:0]         w_x;
  logic [12:0]         w_y;
  logic [12:0]         w_z;
  logic                w_inb;
  logic [ADDR_W-1:0]   w_lin;
  logic                w_last;
  logic                w_ready;

  assign w_x = bus.rast_pt[0];
  assign w_y = bus.rast_pt[1];
  assign w_z = bus.rast_pt[2];

  // Sign bit clear means non-negative; then compare as unsigned.
  assign w_inb = !w_x[12] && !w_y[12]
              && ({19'd0, w_x} < 32'(IMG_W))
              && ({19'd0, w_y} < 32'(IMG_H));

  assign w_lin = ADDR_W'(w_y) * ADDR_W'(IMG_W) + ADDR_W'(w_x);
  assign w_last = (r_addr == ADDR_W'(IMG_W * IMG_H - 1));

  assign w_ready = (r_state == S_IDLE) && !bus.clear_start && !rst;

  function automatic logic [15:0] f_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_z     <= '0;
      r_col   <= '0;
      r_wait  <= '0;
      r_we    <= 1'b0;
      r_zwr   <= '0;
      r_fbd   <= '0;
      r_plot  <= '0;
      r_rej   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.clear_start) begin
            r_state <= S_CLEAR;
            r_addr  <= '0;
            r_we    <= 1'b1;
            r_zwr   <= 13'h0FFF;
            r_fbd   <= '0;
            r_plot  <= '0;
            r_rej   <= '0;
          end else if (bus.rast_pt_valid) begin
            if (w_inb) begin
              r_addr  <= w_lin;
              r_z     <= w_z;
              r_col   <= bus.color;
              r_wait  <= 2'd1;
              // A one-cycle read needs no wait state at all.
              r_state <= (RD_LAT == 1) ? S_DECIDE : S_WAIT;
            end else begin
              r_rej <= f_sat(r_rej);
            end
          end
        end
        S_CLEAR: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wait >= 2'(RD_LAT - 1)) begin
            r_state <= S_DECIDE;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_DECIDE: begin
          if (r_z < $signed(bus.zbuf_rd_data)) begin
            r_state <= S_WRITE;
            r_we    <= 1'b1;
            r_zwr   <= r_z;
            r_fbd   <= r_col;
            r_plot  <= f_sat(r_plot);
          end else begin
            r_state <= S_IDLE;
            r_rej   <= f_sat(r_rej);
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rast_pt_ready  = w_ready;
  assign bus.zbuf_addr      = r_addr;
  assign bus.fb_addr        = r_addr;
  assign bus.zbuf_we        = r_we;
  assign bus.fb_we          = r_we;
  assign bus.zbuf_wr_data   = r_zwr;
  assign bus.fb_data        = r_fbd;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.plotted_count  = r_plot;
  assign bus.rejected_count = r_rej;

endmodule

// File: tb/tb_vertex_plot.sv
// tb_vertex_plot: directed checks of vertex_plot on a 32x32 image.
// Memory model gives a one-register read behind the held address.
module tb_vertex_plot;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 10;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  vertex_plot_if #(.ADDR_W(AW), .COLOR_W(12)) bus ();

  vertex_plot #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW),
    .COLOR_W(12), .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [12:0] zmem [0:N-1];
  logic [12:0] r_rd;

  always @(posedge clk) begin
    if (bus.zbuf_we) zmem[bus.zbuf_addr] <= bus.zbuf_wr_data;
    r_rd <= zmem[bus.zbuf_addr];
  end

  assign bus.zbuf_rd_data = r_rd;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pt(input int x, input int y, input int z,
                        input logic [11:0] c);
    bus.rast_pt[0] = 13'(x);
    bus.rast_pt[1] = 13'(y);
    bus.rast_pt[2] = 13'(z);
    bus.color      = c;
  endtask

  task automatic chk_cnt(input string tag, input int p, input int r);
    chk(tag, {bus.plotted_count, bus.rejected_count},
        {16'(p), 16'(r)});
  endtask

  // Clear started at a negedge; optional coincident point and a
  // stray clear_start part-way through.
  task automatic do_clear(input bit with_pt);
    bus.clear_start = 1'b1;
    if (with_pt) begin
      set_pt(1, 1, 0, 12'hABC);
      bus.rast_pt_valid = 1'b1;
    end
    #1 chk("clr_rdy", {63'd0, bus.rast_pt_ready}, 64'd0);
    @(negedge clk);
    bus.clear_start   = 1'b0;
    bus.rast_pt_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("clr_wr",
          {bus.zbuf_we, bus.fb_we, bus.busy, bus.rast_pt_ready,
           bus.zbuf_addr, bus.fb_addr, bus.zbuf_wr_data, bus.fb_data},
          {4'b1110, AW'(i), AW'(i), 13'h0FFF, 12'h000});
      bus.clear_start = (i == 10);
      @(negedge clk);
    end
    chk("clr_end", {61'd0, bus.zbuf_we, bus.busy, bus.rast_pt_ready},
        64'd1);
  endtask

  // In-bounds point at a negedge; walks accept, WAIT, DECIDE, WRITE.
  task automatic do_pt(input int x, input int y, input int z,
                       input logic [11:0] c, input bit wr);
    logic [AW-1:0] a;
    a = AW'(y * W + x);
    set_pt(x, y, z, c);
    bus.rast_pt_valid = 1'b1;
    #1 chk("pt_rdy", {63'd0, bus.rast_pt_ready}, 64'd1);
    @(negedge clk);
    bus.rast_pt_valid = 1'b0;
    chk("pt_addr", {bus.zbuf_addr, bus.fb_addr, bus.busy, bus.zbuf_we},
        {a, a, 2'b10});
    @(negedge clk);
    chk("pt_dec", {62'd0, bus.zbuf_we, bus.rast_pt_ready}, 64'd0);
    @(negedge clk);
    if (wr) begin
      chk("pt_wr",
          {bus.zbuf_we, bus.fb_we, bus.rast_pt_ready, bus.zbuf_addr,
           bus.zbuf_wr_data, bus.fb_data},
          {3'b110, a, 13'(z), c});
      @(negedge clk);
    end
    chk("pt_done", {61'd0, bus.zbuf_we, bus.busy, bus.rast_pt_ready},
        64'd1);
  endtask

  initial begin
    bus.rast_pt_valid = 1'b0;
    bus.clear_start   = 1'b0;
    set_pt(0, 0, 0, 12'h000);

    repeat (3) @(negedge clk);
    chk("rst_state",
        {bus.rast_pt_ready, bus.busy, bus.zbuf_we, bus.fb_we,
         bus.zbuf_addr, bus.plotted_count, bus.rejected_count},
        64'd0);
    rst = 1'b0;
    #1 chk("rst_rel", {62'd0, bus.rast_pt_ready, bus.busy}, 64'd2);
    @(negedge clk);

    do_clear(1'b0);
    chk_cnt("cnt_clr0", 0, 0);

    do_pt(20, 23, -2, 12'hF00, 1'b1);
    chk_cnt("cnt_p1", 1, 0);
    do_pt(20, 23, 5, 12'h0F0, 1'b0);
    chk_cnt("cnt_z5", 1, 1);
    do_pt(20, 23, -2, 12'h00F, 1'b0);
    chk_cnt("cnt_eq", 1, 2);
    do_pt(20, 23, -7, 12'h0F0, 1'b1);
    chk_cnt("cnt_z7", 2, 2);
    chk("zmem", {51'd0, zmem[756]}, {51'd0, 13'h1FF9});

    bus.rast_pt_valid = 1'b1;
    set_pt(-1, 0, 0, 12'h111);
    #1 chk("oob0", {62'd0, bus.rast_pt_ready, bus.zbuf_we}, 64'd2);
    @(negedge clk);
    set_pt(W, 3, 0, 12'h222);
    #1 chk("oob1", {62'd0, bus.rast_pt_ready, bus.zbuf_we}, 64'd2);
    @(negedge clk);
    set_pt(4, H, 0, 12'h333);
    #1 chk("oob2", {62'd0, bus.rast_pt_ready, bus.zbuf_we}, 64'd2);
    @(negedge clk);
    bus.rast_pt_valid = 1'b0;
    chk("oob_end", {62'd0, bus.rast_pt_ready, bus.zbuf_we}, 64'd2);
    chk_cnt("cnt_oob", 2, 5);

    do_clear(1'b1);
    chk_cnt("cnt_clr1", 0, 0);
    chk("zmem_clr", {51'd0, zmem[33]}, {51'd0, 13'h0FFF});

    do_pt(1, 1, 4095, 12'h777, 1'b0);
    chk_cnt("cnt_max", 0, 1);

    set_pt(2, 2, 0, 12'h444);
    bus.rast_pt_valid = 1'b1;
    @(negedge clk);
    bus.rast_pt_valid = 1'b0;
    chk("wait_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1 chk("rst_wait",
           {bus.zbuf_we, bus.fb_we, bus.busy, bus.rast_pt_ready,
            bus.plotted_count, bus.rejected_count},
           64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_wait", {62'd0, bus.rast_pt_ready, bus.busy}, 64'd2);
    @(negedge clk);

    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_clr", {61'd0, bus.zbuf_we, bus.fb_we, bus.busy}, 64'd7);
    rst = 1'b1;
    #1 chk("rst_clr",
           {bus.zbuf_we, bus.fb_we, bus.busy, bus.rast_pt_ready,
            bus.plotted_count, bus.rejected_count},
           64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_clr", {62'd0, bus.rast_pt_ready, bus.busy}, 64'd2);
    @(negedge clk);
    chk("no_resume", {62'd0, bus.zbuf_we, bus.busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
